// File: rtl/image_feeder.sv
// Pixel-buffer front end for the CNN core: the host loads one image, a go pulse
// streams it to the core on demand, and the one-hot classification is captured.
module image_feeder #(
    parameter int NPIX = 784,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [9:0]           wr_addr,
    input  logic signed [DW-1:0] wr_data,
    input  logic                 go,
    output logic                 cnn_start,
    output logic signed [DW-1:0] cnn_din,
    input  logic                 cnn_din_ready,
    input  logic                 cnn_conv1_done,
    input  logic                 cnn_done,
    input  logic [9:0]           cnn_classes,
    output logic                 busy,
    output logic [9:0]           result,
    output logic [3:0]           class_idx,
    output logic                 result_valid,
    output logic                 underrun,
    output logic                 wr_err
);

    localparam int IW = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESULT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [DW-1:0]  r_buf [NPIX];
    logic [IW-1:0]         r_pix_idx;
    logic signed [DW-1:0]  r_cnn_din;
    logic [9:0]            r_result;
    logic [3:0]            r_class_idx;
    logic                  r_underrun;
    logic                  r_wr_err;
    logic                  w_host_side;
    logic                  w_go_ok;
    logic                  w_wr_ok;
    logic                  w_capture;
    logic                  w_pix_end;
    logic [3:0]            w_class_idx;

    assign w_host_side = (r_state == IDLE) || (r_state == RESULT);
    assign w_go_ok     = go && w_host_side;
    assign w_wr_ok     = wr_en && w_host_side && ({22'd0, wr_addr} < 32'(NPIX));
    assign w_capture   = cnn_done && ((r_state == STREAM) || (r_state == WAIT_DONE));
    assign w_pix_end   = (r_pix_idx >= IW'(NPIX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // cnn_done wins over cnn_conv1_done when both arrive in STREAM
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RESULT: if (go) w_next = STREAM;
            STREAM: begin
                if (cnn_done)            w_next = RESULT;
                else if (cnn_conv1_done) w_next = WAIT_DONE;
            end
            WAIT_DONE:    if (cnn_done) w_next = RESULT;
            default:      w_next = IDLE;
        endcase
    end

    always_comb begin
        cnn_start    = (r_state == STREAM);
        busy         = (r_state == STREAM) || (r_state == WAIT_DONE);
        result_valid = (r_state == RESULT);
    end

    always_comb begin
        w_class_idx = 4'd15;
        for (int i = 9; i >= 0; i--) begin
            if (cnn_classes[i]) w_class_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_buf[wr_addr] <= wr_data;
    end

    // Requests past the end of the image feed zeros and flag the underrun
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnn_din   <= '0;
            r_pix_idx   <= '0;
            r_underrun  <= 1'b0;
            r_result    <= '0;
            r_class_idx <= 4'd15;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            if (w_go_ok) begin
                r_pix_idx  <= '0;
                r_underrun <= 1'b0;
            end else if ((r_state == STREAM) && cnn_din_ready) begin
                if (!w_pix_end) begin
                    r_cnn_din <= r_buf[r_pix_idx];
                    r_pix_idx <= r_pix_idx + IW'(1);
                end else begin
                    r_cnn_din  <= '0;
                    r_underrun <= 1'b1;
                end
            end
            if (w_capture) begin
                r_result    <= cnn_classes;
                r_class_idx <= w_class_idx;
            end
        end
    end

    assign cnn_din   = r_cnn_din;
    assign result    = r_result;
    assign class_idx = r_class_idx;
    assign underrun  = r_underrun;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_image_feeder.sv
// Randomized bench for image_feeder: an array/queue-style model of the image
// and the requested pixel stream predicts every cnn_din value and result.
module tb_image_feeder;

    localparam int NPIX = 784;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 wr_en;
    logic [9:0]           wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 go;
    logic                 cnn_start;
    logic signed [DW-1:0] cnn_din;
    logic                 cnn_din_ready;
    logic                 cnn_conv1_done;
    logic                 cnn_done;
    logic [9:0]           cnn_classes;
    logic                 busy;
    logic [9:0]           result;
    logic [3:0]           class_idx;
    logic                 result_valid;
    logic                 underrun;
    logic                 wr_err;

    int                   vectorCount = 0;
    int                   missCount   = 0;
    int                   modelBuf [NPIX];
    int                   modelIdx;
    logic signed [DW-1:0] modelDin;
    bit                   modelUnderrun;
    logic [9:0]           modelResult;

    image_feeder #(.NPIX(NPIX), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .cnn_start(cnn_start), .cnn_din(cnn_din), .cnn_din_ready(cnn_din_ready),
        .cnn_conv1_done(cnn_conv1_done), .cnn_done(cnn_done), .cnn_classes(cnn_classes),
        .busy(busy), .result(result), .class_idx(class_idx), .result_valid(result_valid),
        .underrun(underrun), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] lowestClass(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
        return 4'd15;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start"}, cnn_start, 0);
        checkOutput({tag, "_din"}, cnn_din, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_result"}, result, 0);
        checkOutput({tag, "_class"}, class_idx, 15);
        checkOutput({tag, "_valid"}, result_valid, 0);
        checkOutput({tag, "_underrun"}, underrun, 0);
        checkOutput({tag, "_wrerr"}, wr_err, 0);
    endtask

    task automatic writePixel(input int addr, input logic [DW-1:0] data, input bit expErr);
        wr_en   = 1'b1;
        wr_addr = 10'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        checkOutput("wr_err", wr_err, expErr);
        if (!expErr) modelBuf[addr] = int'(data);
    endtask

    // Accept a go, then serve nReq pixel requests at a random ready rate
    task automatic applyStimulus(input int readyPct, input int nReq, input bit disturb);
        int served = 0;
        int cyc = 0;
        int errPhase = 0;
        cnn_din_ready = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        modelIdx = 0;
        modelUnderrun = 0;
        checkOutput("go_busy", busy, 1);
        checkOutput("go_start", cnn_start, 1);
        checkOutput("go_valid", result_valid, 0);
        checkOutput("go_underrun", underrun, 0);
        while (served < nReq && cyc < 20000) begin
            cnn_din_ready = ($urandom_range(99) < readyPct);
            go = disturb && ($urandom_range(9) == 0);
            if (disturb && errPhase == 0 && served >= 100) begin
                wr_en = 1'b1;
                wr_addr = 10'd3;
                wr_data = $urandom;
                errPhase = 1;
            end
            tick();
            cyc++;
            if (cnn_din_ready) begin
                served++;
                if (modelIdx < NPIX) begin
                    modelDin = modelBuf[modelIdx];
                    modelIdx++;
                end else begin
                    modelDin = '0;
                    modelUnderrun = 1;
                end
            end
            checkOutput("stream_din", cnn_din, modelDin);
            checkOutput("stream_underrun", underrun, modelUnderrun);
            if (errPhase == 1) begin
                wr_en = 1'b0;
                checkOutput("busy_wr_err", wr_err, 1);
                errPhase = 2;
            end else if (errPhase == 2) begin
                checkOutput("busy_wr_err_end", wr_err, 0);
                errPhase = 3;
            end
        end
        go = 1'b0;
        wr_en = 1'b0;
        cnn_din_ready = 1'b0;
        checkOutput("stream_served", served, nReq);
    endtask

    task automatic endStream(input logic [9:0] classes, input bit sameEdge);
        logic [9:0] other;
        if (sameEdge) begin
            cnn_conv1_done = 1'b1;
        end else begin
            cnn_conv1_done = 1'b1;
            tick();
            cnn_conv1_done = 1'b0;
            checkOutput("conv1_start_drop", cnn_start, 0);
            checkOutput("conv1_busy", busy, 1);
            for (int k = 0; k < 1 + int'($urandom_range(4)); k++) begin
                cnn_din_ready = $urandom_range(1);
                go = $urandom_range(1);
                tick();
                checkOutput("wait_din_hold", cnn_din, modelDin);
                checkOutput("wait_start", cnn_start, 0);
                checkOutput("wait_busy", busy, 1);
            end
            cnn_din_ready = 1'b0;
            go = 1'b0;
        end
        cnn_done = 1'b1;
        cnn_classes = classes;
        tick();
        cnn_done = 1'b0;
        cnn_conv1_done = 1'b0;
        modelResult = classes;
        checkOutput("res_result", result, modelResult);
        checkOutput("res_class", class_idx, lowestClass(modelResult));
        checkOutput("res_valid", result_valid, 1);
        checkOutput("res_busy", busy, 0);
        checkOutput("res_start", cnn_start, 0);
        checkOutput("res_underrun", underrun, modelUnderrun);
        other = ~classes;
        cnn_done = 1'b1;
        cnn_classes = other;
        cnn_din_ready = 1'b1;
        tick();
        cnn_done = 1'b0;
        cnn_din_ready = 1'b0;
        checkOutput("hold_result", result, modelResult);
        checkOutput("hold_class", class_idx, lowestClass(modelResult));
        checkOutput("hold_valid", result_valid, 1);
        checkOutput("hold_underrun", underrun, modelUnderrun);
        checkOutput("hold_din", cnn_din, modelDin);
    endtask

    initial begin
        rstn = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        go = 1'b0;
        cnn_din_ready = 1'b0;
        cnn_conv1_done = 1'b0;
        cnn_done = 1'b0;
        cnn_classes = '0;
        modelDin = '0;
        modelUnderrun = 0;
        #3 rstn = 1'b0;
        #9 checkResetValues("por");
        rstn = 1'b1;

        writePixel(800, 32'h1234, 1);
        for (int i = 0; i < NPIX; i++) writePixel(i, i, 0);

        $display("[TB] run 1: full-rate stream of ramp image");
        applyStimulus(100, NPIX, 0);
        endStream(10'b0000100000, 0);

        for (int i = 0; i < NPIX; i++) writePixel(i, $urandom, 0);
        writePixel(800, 32'h55, 1);

        $display("[TB] run 2: 50%% ready, busy writes and stray go");
        applyStimulus(50, NPIX, 1);
        endStream(10'($urandom), 0);

        $display("[TB] run 3: over-request by two pixels");
        applyStimulus(70, NPIX + 2, 0);
        endStream(10'b1000000100, 0);

        $display("[TB] run 4: reset at pixel 400");
        applyStimulus(100, 400, 0);
        rstn = 1'b0;
        #1;
        modelDin = '0;
        modelUnderrun = 0;
        checkResetValues("midrst");
        rstn = 1'b1;
        applyStimulus(60, NPIX, 0);
        endStream(10'b0, 1);
        writePixel(800, 32'h77, 1);
        writePixel(5, $urandom, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/image_feeder.md
IMAGE_FEEDER -- requirements
Module: image_feeder

Interface
REQ-001 Parameter NPIX, default 784: pixels per image.
REQ-002 Parameter DW, default 32: signed pixel width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  host pixel-buffer write strobe.
REQ-006 wr_addr  input  10  host write address, 0..NPIX-1.
REQ-007 wr_data  input  DW  host write pixel.
REQ-008 go  input  1  single-cycle request to run one inference.
REQ-009 cnn_start  output  1  start level to the CNN core.
REQ-010 cnn_din  output  DW  pixel stream to the CNN core.
REQ-011 cnn_din_ready  input  1  CNN requests next pixel.
REQ-012 cnn_conv1_done  input  1  CNN finished consuming input.
REQ-013 cnn_done  input  1  CNN classification complete.
REQ-014 cnn_classes  input  10  CNN one-hot class vector.
REQ-015 busy  output  1  high from accepted go until result capture.
REQ-016 result  output  10  captured class vector.
REQ-017 class_idx  output  4  index of lowest set bit of result; 15 if none.
REQ-018 result_valid  output  1  result/class_idx valid.
REQ-019 underrun  output  1  sticky: CNN requested more than NPIX pixels.
REQ-020 wr_err  output  1  one-cycle pulse: host write rejected.

Function
REQ-021 The block SHALL hold an NPIX x DW pixel buffer, written at wr_addr when wr_en=1 and state is IDLE or RESULT.
REQ-022 Writes while busy, or with wr_addr >= NPIX, SHALL be dropped and SHALL pulse wr_err for one cycle.
REQ-023 The FSM SHALL have states IDLE, STREAM, WAIT_DONE, RESULT.
REQ-024 IDLE/RESULT + go=1 -> STREAM; pix_idx cleared, result_valid cleared, underrun cleared, busy set, same edge.
REQ-025 go in STREAM or WAIT_DONE SHALL be ignored.
REQ-026 cnn_start SHALL be 1 in STREAM only, deasserting the cycle after cnn_conv1_done is sampled high.
REQ-027 In STREAM, on each edge with cnn_din_ready=1: cnn_din <= buffer[pix_idx], pix_idx <= pix_idx+1 (registered, one-cycle latency).
REQ-028 cnn_din SHALL hold its value on edges with cnn_din_ready=0.
REQ-029 When pix_idx >= NPIX and cnn_din_ready=1, cnn_din <= 0, pix_idx saturates at NPIX, underrun set.
REQ-030 STREAM + cnn_conv1_done=1 -> WAIT_DONE; cnn_din_ready ignored outside STREAM.
REQ-031 STREAM/WAIT_DONE + cnn_done=1 -> RESULT: result <= cnn_classes, class_idx computed from same value, result_valid <= 1, busy <= 0.
REQ-032 cnn_done and cnn_conv1_done high on the same edge in STREAM SHALL take the RESULT transition.
REQ-033 cnn_done in IDLE or RESULT SHALL be ignored; result unchanged.
REQ-034 RESULT SHALL hold result, class_idx, result_valid until the next accepted go.
REQ-035 cnn_classes multiple-hot: class_idx = lowest set index; all-zero: class_idx = 15.

Reset
REQ-036 rstn=0 SHALL immediately force: state IDLE, cnn_start 0, cnn_din 0, pix_idx 0, busy 0, result 0, class_idx 15, result_valid 0, underrun 0, wr_err 0.
REQ-037 Reset mid-STREAM SHALL abort the run with the above values; pixel buffer contents need not be cleared.
REQ-038 After rstn rises, the first go SHALL be accepted on the first edge.

Verification
REQ-039 Load buffer[i]=i, go, CNN model asserts din_ready every cycle for 784 cycles -> cnn_din sequence 0..783 one cycle after each request, underrun=0.
REQ-040 din_ready toggled randomly (50%) -> cnn_din sequence still 0..783 exactly, no repeats or skips; cnn_start drops the cycle after conv1_done.
REQ-041 CNN requests 786 pixels -> last two cnn_din values 0, underrun=1 held until next go.
REQ-042 cnn_done with cnn_classes=10'b0000100000 -> result=0x020, class_idx=5, result_valid=1, busy=0; cnn_classes=0 -> class_idx=15.
REQ-043 wr_en during STREAM at addr 3 -> wr_err pulses one cycle, buffer[3] unchanged on next run; wr_addr=800 in IDLE -> wr_err pulse.
REQ-044 rstn low at pixel 400 -> all outputs at reset values same cycle; subsequent go restreams from pixel 0.
